uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Serial transmit path fed by the CPU datapath's UART store port (DataIn / DataInValid / DataInReady).
- Buffers bytes written by SW/SB to the UART TX address in a small FIFO, then serialises them 8N1, LSB first, on the SOut pin.
- Decouples the datapath from the baud rate, so back-to-back UART stores do not stall the pipeline until the FIFO fills.

Parameters:
- CLOCK_FREQ, 50_000_000: core clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate in bits per second.
- FIFO_DEPTH, 8: TX buffer entries; must be a power of 2, at least 2.

Ports:
- CLK  in  1  core clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- DataIn  in  8  byte to transmit, from the datapath.
- DataInValid  in  1  datapath offers DataIn this cycle.
- DataInReady  out  1  buffer can accept a byte; equals not-full.
- Flush  in  1  synchronous FIFO clear; does not abort the frame in flight.
- SOut  out  1  serial line; idles high.
- TxBusy  out  1  frame in flight or FIFO non-empty.
- TxCount  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Derived constants:
  - CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer division, truncated.
  - Baud counter width = clog2(CYCLES_PER_BIT).
  - CYCLES_PER_BIT must be at least 2; otherwise elaboration fails via a generate-time check.
- Reset (reset = 0, asynchronous):
  - FIFO pointers and count go to 0; FSM goes to IDLE; shift register is all 1s; bit and baud counters are 0.
  - Outputs: SOut = 1, DataInReady = 1, TxBusy = 0, TxCount = 0.
  - Reset asserted mid-frame: SOut returns to 1 immediately (asynchronously); the partial frame and buffered bytes are lost.
- Push: when DataInValid and DataInReady are both high at a clock edge, DataIn is written at wr_ptr, wr_ptr increments modulo FIFO_DEPTH, and count increments.
- DataInReady and TxBusy are derived from registered count only. There is no combinational path from DataInValid to DataInReady.
- Full FIFO (count = FIFO_DEPTH):
  - DataInReady = 0; the datapath holds its store.
  - A pop in the same cycle does not re-open ready until the next cycle.
- FSM, two states:
  - IDLE:
    - If count != 0 and Flush = 0: pop the entry at rd_ptr (rd_ptr increments, count decrements).
    - Load shift register = {1'b1, byte, 1'b0} (10 bits).
    - Set baud counter = 0, bit counter = 0, go to SHIFT.
    - Otherwise stay in IDLE with SOut = 1.
  - SHIFT:
    - SOut = shift[0].
    - Baud counter increments each cycle.
    - When baud counter = CYCLES_PER_BIT-1: counter returns to 0, shift register shifts right filling 1, bit counter increments.
    - When bit counter = 9 and baud counter = CYCLES_PER_BIT-1, go to IDLE.
  - Each bit, including the stop bit, lasts exactly CYCLES_PER_BIT cycles.
- Latency:
  - Push to an empty, idle buffer at edge t: the FIFO is non-empty after t, the FSM pops at edge t+1, and SOut falls (start bit) after edge t+1.
  - Frame length = 10 * CYCLES_PER_BIT cycles.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between stop and next start, so frame period = 10 * CYCLES_PER_BIT + 1 cycles.
- Simultaneous push and pop: count is unchanged, both pointers advance. Legal at any occupancy below full.
- Empty FIFO: no bypass; a byte pushed while empty is popped only on the following cycle.
- Flush = 1:
  - Pointers and count are cleared next edge; a concurrent push is discarded.
  - The frame in SHIFT completes normally.
  - In IDLE with Flush = 1, no pop occurs.
- Pointer wrap-around: pointers are clog2(FIFO_DEPTH) bits and wrap naturally; full/empty is determined from count, not pointer compare.
- TxBusy = (state == SHIFT) or (count != 0).
- TxCount = count.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE, SHIFT);
  - FRAME_BITS = 10;
  - clog2 function, shared with the RX side.
- Natural sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: push/pop/flush, full/empty/count.
  - Reused by the future UART RX buffer.
- The top level holds the baud counter, shift register and FSM.

Test Plan (CLOCK_FREQ=100, BAUD_RATE=10, so CYCLES_PER_BIT=10; FIFO_DEPTH=4):
- Reset check: hold reset=0 for 3 cycles mid-stream -> SOut=1, DataInReady=1, TxBusy=0, TxCount=0 immediately. After release, no stale frame is sent.
- Single byte: push 8'hA5 at edge 0 ->
  - SOut=0 during cycles 2..11;
  - then data bits 1,0,1,0,0,1,0,1 (LSB first) for 10 cycles each;
  - stop bit 1 for 10 cycles;
  - TxBusy drops after cycle 101.
- Fill and back-pressure: push 6 consecutive bytes 8'h01..8'h06 with DataInValid held high ->
  - DataInReady low once count=4;
  - all 6 bytes appear on SOut in order;
  - start bits exactly 101 cycles apart.
- Simultaneous push/pop: push one byte into an empty FIFO at the same edge as the FSM pops the previous byte -> TxCount unchanged, both bytes transmitted in order.
- Flush mid-frame: queue 8'h11, 8'h22, 8'h33; pulse Flush during the first frame ->
  - 8'h11 frame completes intact;
  - 8'h22 and 8'h33 are never sent;
  - TxCount=0 the cycle after Flush.
- Async reset mid-frame: drop reset during bit 4 of 8'hFF ->
  - SOut=1 without waiting for an edge;
  - after release, a new push of 8'h3C transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and width helper
package uart_pkg;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; occupancy-based full/empty
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("sync_fifo DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally; occupancy alone decides full and empty.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter fed by the datapath store port
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [7:0]                  DataIn,
  input  logic                        DataInValid,
  output logic                        DataInReady,
  input  logic                        Flush,
  output logic                        SOut,
  output logic                        TxBusy,
  output logic [clog2(FIFO_DEPTH):0]  TxCount
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W         = clog2(CYCLES_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(FRAME_BITS - 1);

  if (CYCLES_PER_BIT < 2) begin : g_baud_check
    $error("uart_tx_buffered needs CLOCK_FREQ / BAUD_RATE >= 2");
  end

  tx_state_t               state_q;
  tx_state_t               state_d;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [BAUD_W-1:0]       baud_q;
  logic [3:0]              bit_q;
  logic                    pop;
  logic [7:0]              fifo_data;
  logic                    fifo_full;
  logic                    fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (DataInValid),
    .push_data (DataIn),
    .pop       (pop),
    .pop_data  (fifo_data),
    .flush     (Flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (TxCount)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !Flush) begin
          pop     = 1'b1;
          state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if ((baud_q == BAUD_LAST) && (bit_q == LAST_BIT)) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        shift_q <= {1'b1, fifo_data, 1'b0};
        baud_q  <= '0;
        bit_q   <= '0;
      end else if (state_q == TX_SHIFT) begin
        if (baud_q == BAUD_LAST) begin
          baud_q  <= '0;
          bit_q   <= bit_q + 1'b1;
          shift_q <= {1'b1, shift_q[FRAME_BITS-1:1]};
        end else begin
          baud_q <= baud_q + 1'b1;
        end
      end
    end
  end

  // Line is driven from reset-cleared registers only, so reset forces idle-high at once.
  assign SOut        = (state_q == TX_SHIFT) ? shift_q[0] : 1'b1;
  assign DataInReady = !fifo_full;
  assign TxBusy      = (state_q == TX_SHIFT) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       DataInValid = 1'b0;
  logic       Flush = 1'b0;
  logic       DataInReady;
  logic       SOut;
  logic       TxBusy;
  logic [2:0] TxCount;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .CLOCK_FREQ (100),
    .BAUD_RATE  (10),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .Flush       (Flush),
    .SOut        (SOut),
    .TxBusy      (TxBusy),
    .TxCount     (TxCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[idx];
  endfunction

  // Behavioural model: a byte queue plus the edge at which the current frame started.
  logic [7:0] mq[$];
  logic       m_act  = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_edge = 0;
  int         ecount = 0;

  always @(posedge CLK) begin
    logic pre_full;
    logic exp_sout;
    ecount++;
    if (!reset) begin
      mq.delete();
      m_act = 1'b0;
    end else begin
      pre_full = (mq.size() == DEPTH);
      if (!m_act && (mq.size() != 0) && !Flush) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_edge = ecount;
      end else if (m_act && (ecount - m_edge == 10 * CPB)) begin
        m_act = 1'b0;
      end
      if (Flush) mq.delete();
      else if (DataInValid && !pre_full) mq.push_back(DataIn);
    end
    #1;
    exp_sout = m_act ? frame_bit(m_byte, (ecount - m_edge) / CPB) : 1'b1;
    check("model_sout",  32'(SOut),        32'(exp_sout));
    check("model_count", 32'(TxCount),     32'(mq.size()));
    check("model_ready", 32'(DataInReady), 32'(mq.size() < DEPTH));
    check("model_busy",  32'(TxBusy),      32'(m_act || (mq.size() != 0)));
  end

  // Line receiver: decodes frames from SOut and records each start-bit cycle.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         cyc = 0;
  logic       rx_busy = 1'b0;
  int         rx_start = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge CLK) begin
    int off;
    cyc++;
    if (!reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (SOut == 1'b0) begin
        rx_busy  = 1'b1;
        rx_start = cyc;
      end
    end else begin
      off = cyc - rx_start;
      if (off % CPB == CPB / 2) begin
        if ((off / CPB >= 1) && (off / CPB <= 8)) begin
          rx_byte[off / CPB - 1] = SOut;
        end else if (off / CPB == 9) begin
          check("rx_stop_bit", 32'(SOut), 32'd1);
          rx_q.push_back(rx_byte);
          rx_t.push_back(rx_start);
          rx_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    DataIn      = b;
    DataInValid = 1'b1;
    while (!DataInReady && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    check("push_ready_timeout", 32'(DataInReady), 32'd1);
    @(negedge CLK);
    DataInValid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (TxBusy && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    check("idle_timeout", 32'(TxBusy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    logic [9:0] a5_frame;
    a5_frame = 10'b1_1010_0101_0;

    repeat (3) @(negedge CLK);
    check("rst_sout",  32'(SOut),        32'd1);
    check("rst_ready", 32'(DataInReady), 32'd1);
    check("rst_busy",  32'(TxBusy),      32'd0);
    check("rst_count", 32'(TxCount),     32'd0);
    reset = 1'b1;
    wait_n(2);

    // Single byte A5: start bit one edge after the push, LSB first.
    n0 = rx_q.size();
    push_byte(8'hA5);
    check("a5_count", 32'(TxCount), 32'd1);
    wait_n(6);
    check("a5_start", 32'(SOut), 32'(a5_frame[0]));
    for (int b = 1; b < 10; b++) begin
      wait_n(10);
      check("a5_bit", 32'(SOut), 32'(a5_frame[b]));
    end
    wait_n(4);
    check("a5_busy_last", 32'(TxBusy), 32'd1);
    wait_n(1);
    check("a5_busy_drop", 32'(TxBusy), 32'd0);
    wait_n(5);
    check("a5_rx_n", 32'(rx_q.size()), 32'(n0 + 1));
    if (rx_q.size() > n0) check("a5_rx_byte", 32'(rx_q[n0]), 32'h0000_00A5);

    // Fill and back-pressure.
    n0 = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      push_byte(8'(i + 1));
      if (i == 4) begin
        check("fill_count", 32'(TxCount),     32'd4);
        check("fill_ready", 32'(DataInReady), 32'd0);
      end
    end
    wait_idle();
    wait_n(5);
    check("fill_rx_n", 32'(rx_q.size()), 32'(n0 + 6));
    if (rx_q.size() >= n0 + 6) begin
      for (int i = 0; i < 6; i++) check("fill_rx_byte", 32'(rx_q[n0 + i]), 32'(i + 1));
      for (int i = 0; i < 5; i++) check("fill_period", 32'(rx_t[n0 + i + 1] - rx_t[n0 + i]), 32'd101);
    end

    // Push into an empty FIFO on the same edge the FSM pops.
    n0 = rx_q.size();
    push_byte(8'h5A);
    check("sim_count1", 32'(TxCount), 32'd1);
    push_byte(8'hC3);
    check("sim_count2", 32'(TxCount), 32'd1);
    check("sim_busy",   32'(TxBusy),  32'd1);
    wait_idle();
    wait_n(5);
    check("sim_rx_n", 32'(rx_q.size()), 32'(n0 + 2));
    if (rx_q.size() >= n0 + 2) begin
      check("sim_rx_0", 32'(rx_q[n0]),     32'h0000_005A);
      check("sim_rx_1", 32'(rx_q[n0 + 1]), 32'h0000_00C3);
    end

    // Flush mid-frame, with a push offered in the flush cycle.
    n0 = rx_q.size();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("flush_pre_count", 32'(TxCount), 32'd2);
    wait_n(30);
    Flush       = 1'b1;
    DataIn      = 8'h77;
    DataInValid = 1'b1;
    @(negedge CLK);
    Flush       = 1'b0;
    DataInValid = 1'b0;
    check("flush_count", 32'(TxCount), 32'd0);
    check("flush_busy",  32'(TxBusy),  32'd1);
    wait_idle();
    wait_n(120);
    check("flush_rx_n", 32'(rx_q.size()), 32'(n0 + 1));
    if (rx_q.size() > n0) check("flush_rx_byte", 32'(rx_q[n0]), 32'h0000_0011);

    // Asynchronous reset during bit 4 of FF with another byte queued.
    n0 = rx_q.size();
    push_byte(8'hFF);
    push_byte(8'h99);
    wait_n(44);
    check("pre_rst_sout", 32'(SOut), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_sout",  32'(SOut),        32'd1);
    check("arst_ready", 32'(DataInReady), 32'd1);
    check("arst_busy",  32'(TxBusy),      32'd0);
    check("arst_count", 32'(TxCount),     32'd0);
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    wait_n(250);
    check("arst_no_stale", 32'(rx_q.size()), 32'(n0));
    check("arst_idle",     32'(TxBusy),      32'd0);
    push_byte(8'h3C);
    wait_idle();
    wait_n(5);
    check("arst_rx_n", 32'(rx_q.size()), 32'(n0 + 1));
    if (rx_q.size() > n0) check("arst_rx_byte", 32'(rx_q[n0]), 32'h0000_003C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
